// File: rtl/scan_reg_pkg.sv
// -----------------------------------------------------------------------------
// scan_reg_pkg
// Shared types and helpers for the scannable register bank.
//   state_e : auto-shift controller states (IDLE, SHIFT, DONE)
//   cnt_w() : auto-shift counter width for a given segment length,
//             max(1, $clog2(len)) so a 1-bit segment still gets a counter bit
// -----------------------------------------------------------------------------
package scan_reg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic int cnt_w(input int len);
        int w;
        w = $clog2(len);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage : scan_reg_pkg

// File: rtl/scan_seg.sv
// -----------------------------------------------------------------------------
// scan_seg
// One LEN-bit scan segment of the register bank.
//   clk_i     : clock, posedge
//   rst_i     : asynchronous active-high reset, loads rst_val_i
//   shift_i   : shift one bit toward the LSB, si_i enters at the MSB
//   load_i    : functional parallel load of d_i (shift has priority)
//   d_i       : functional data slice
//   si_i      : scan input bit
//   rst_val_i : reset value for this slice
//   q_o       : segment contents
//   so_o      : scan output, the LSB (exits first)
// -----------------------------------------------------------------------------
module scan_seg #(
    parameter int LEN = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           shift_i,
    input  logic           load_i,
    input  logic [LEN-1:0] d_i,
    input  logic           si_i,
    input  logic [LEN-1:0] rst_val_i,
    output logic [LEN-1:0] q_o,
    output logic           so_o
);

    logic [LEN-1:0] q_q;
    logic [LEN-1:0] q_d;
    logic [LEN-1:0] shifted_s;

    // A single-bit segment simply takes the scan input on a shift.
    generate
        if (LEN == 1) begin : g_len1
            assign shifted_s = si_i;
        end else begin : g_lenn
            assign shifted_s = {si_i, q_q[LEN-1:1]};
        end
    endgenerate

    // Next-state selection: shift beats load beats hold.
    always_comb begin
        q_d = q_q;
        if (shift_i) begin
            q_d = shifted_s;
        end else if (load_i) begin
            q_d = d_i;
        end else begin
            q_d = q_q;
        end
    end

    // Segment storage with asynchronous reset to the supplied value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= rst_val_i;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o  = q_q;
    assign so_o = q_q[0];

endmodule : scan_seg

// File: rtl/scan_reg_bank.sv
// -----------------------------------------------------------------------------
// scan_reg_bank
// WIDTH-bit scannable register bank split into CHAINS segments of
// LEN = WIDTH/CHAINS bits, with an auto-shift controller that shifts a full
// segment length after one SHIFT_START pulse.
//   CLK         : clock, posedge
//   RST         : asynchronous active-high reset
//   D / EN      : functional data and load enable
//   SE / SI     : manual scan enable, scan input (one bit per segment)
//   SO          : scan output, SO[k] = Q[k*LEN]
//   SHIFT_START : start an auto-shift of LEN cycles (ignored unless IDLE)
//   SHIFT_BUSY  : high while auto-shift is in progress
//   SHIFT_DONE  : one-cycle pulse after the last auto-shift
//   Q / QN      : register contents and their complement
// -----------------------------------------------------------------------------
module scan_reg_bank
    import scan_reg_pkg::*;
#(
    parameter int               WIDTH   = 16,
    parameter int               CHAINS  = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WIDTH-1:0]  D,
    input  logic              EN,
    input  logic              SE,
    input  logic [CHAINS-1:0] SI,
    output logic [CHAINS-1:0] SO,
    input  logic              SHIFT_START,
    output logic              SHIFT_BUSY,
    output logic              SHIFT_DONE,
    output logic [WIDTH-1:0]  Q,
    output logic [WIDTH-1:0]  QN
);

    localparam int LEN = WIDTH / CHAINS;
    localparam int CW  = cnt_w(LEN);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;

    logic          shift_s;
    logic          load_s;
    logic [WIDTH-1:0] q_s;

    // An auto-shift in progress overrides SE and EN entirely.
    assign shift_s = (state_q == SHIFT) || SE;
    assign load_s  = EN && !shift_s;

    // Auto-shift controller: start, count LEN shifts, one-cycle DONE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (SHIFT_START) begin
                        state_q <= SHIFT;
                        cnt_q   <= CW'(LEN - 1);
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        cnt_q   <= cnt_q;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    // The edge that sees cnt_q == 0 performs the last shift.
                    if (cnt_q == {CW{1'b0}}) begin
                        state_q <= DONE;
                        cnt_q   <= cnt_q;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= SHIFT;
                        cnt_q   <= cnt_q - CW'(1);
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    cnt_q   <= cnt_q;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= {CW{1'b0}};
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // One segment per chain; all segments shift together.
    generate
        for (genvar k = 0; k < CHAINS; k++) begin : g_seg
            scan_seg #(
                .LEN(LEN)
            ) u_seg (
                .clk_i    (CLK),
                .rst_i    (RST),
                .shift_i  (shift_s),
                .load_i   (load_s),
                .d_i      (D[k*LEN +: LEN]),
                .si_i     (SI[k]),
                .rst_val_i(RST_VAL[k*LEN +: LEN]),
                .q_o      (q_s[k*LEN +: LEN]),
                .so_o     (SO[k])
            );
        end
    endgenerate

    assign Q          = q_s;
    assign QN         = ~q_s;
    assign SHIFT_BUSY = busy_q;
    assign SHIFT_DONE = done_q;

endmodule : scan_reg_bank

// File: tb/tb_scan_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_scan_reg_bank
// Directed, table-driven bench for scan_reg_bank with WIDTH=8, CHAINS=2
// (LEN=4), plus hand-written auto-shift and reset sequences.
// -----------------------------------------------------------------------------
module tb_scan_reg_bank;

    logic       CLK;
    logic       RST;
    logic [7:0] D;
    logic       EN;
    logic       SE;
    logic [1:0] SI;
    logic [1:0] SO;
    logic       SHIFT_START;
    logic       SHIFT_BUSY;
    logic       SHIFT_DONE;
    logic [7:0] Q;
    logic [7:0] QN;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic       en;
        logic       se;
        logic [7:0] d;
        logic [1:0] si;
        logic [7:0] exp_q;
    } vec_t;

    vec_t vecs [7];

    scan_reg_bank #(
        .WIDTH  (8),
        .CHAINS (2),
        .RST_VAL(8'h00)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .D          (D),
        .EN         (EN),
        .SE         (SE),
        .SI         (SI),
        .SO         (SO),
        .SHIFT_START(SHIFT_START),
        .SHIFT_BUSY (SHIFT_BUSY),
        .SHIFT_DONE (SHIFT_DONE),
        .Q          (Q),
        .QN         (QN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply(input logic en, input logic se, input logic [7:0] d,
                         input logic [1:0] si, input logic [7:0] exp_q);
        EN = en; SE = se; D = d; SI = si;
        tick();
        check("vec_q",    {24'd0, Q},  {24'd0, exp_q});
        check("vec_qn",   {24'd0, QN}, {24'd0, ~exp_q});
        check("vec_busy", {31'd0, SHIFT_BUSY}, 32'd0);
        check("vec_done", {31'd0, SHIFT_DONE}, 32'd0);
    endtask

    // Auto-shift from Q=0xA5 with SI=01; optionally hold EN=1/D=0 after t0
    // and re-pulse SHIFT_START before t2, which must change nothing.
    task automatic run_auto(input bit interfere);
        logic [1:0] exp_so [4];
        exp_so[0] = 2'b01; exp_so[1] = 2'b10; exp_so[2] = 2'b01; exp_so[3] = 2'b10;
        EN = 1'b0; SE = 1'b0; D = 8'hFF; SI = 2'b01;
        SHIFT_START = 1'b1;
        tick();                                  // t0
        SHIFT_START = 1'b0;
        check("t0_q", {24'd0, Q}, 32'h0000_00A5);
        if (interfere) begin
            EN = 1'b1; D = 8'h00;
        end else begin
            EN = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            check("auto_so",   {30'd0, SO}, {30'd0, exp_so[i]});
            check("auto_busy", {31'd0, SHIFT_BUSY}, 32'd1);
            check("auto_done", {31'd0, SHIFT_DONE}, 32'd0);
            if (interfere && i == 1) SHIFT_START = 1'b1;
            tick();                              // t(i+1)
            SHIFT_START = 1'b0;
        end
        check("end_q",    {24'd0, Q},  32'h0000_000F);
        check("end_qn",   {24'd0, QN}, 32'h0000_00F0);
        check("end_busy", {31'd0, SHIFT_BUSY}, 32'd0);
        check("end_done", {31'd0, SHIFT_DONE}, 32'd1);
        EN = 1'b0;
        tick();
        check("post_done", {31'd0, SHIFT_DONE}, 32'd0);
        check("post_busy", {31'd0, SHIFT_BUSY}, 32'd0);
        check("post_q",    {24'd0, Q}, 32'h0000_000F);
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;

        // {en, se, d, si, exp_q}
        vecs[0] = '{1'b1, 1'b0, 8'hA5, 2'b00, 8'hA5};  // load
        vecs[1] = '{1'b0, 1'b0, 8'hFF, 2'b00, 8'hA5};  // hold
        vecs[2] = '{1'b0, 1'b1, 8'h00, 2'b10, 8'hD2};  // one manual shift
        vecs[3] = '{1'b1, 1'b0, 8'h3C, 2'b00, 8'h3C};  // load
        vecs[4] = '{1'b1, 1'b0, 8'hA5, 2'b00, 8'hA5};  // load
        vecs[5] = '{1'b1, 1'b1, 8'h00, 2'b01, 8'h08};  // SE beats EN
        vecs[6] = '{1'b1, 1'b1, 8'h00, 2'b01, 8'h0C};

        RST = 1'b1; D = 8'h00; EN = 1'b0; SE = 1'b0; SI = 2'b00; SHIFT_START = 1'b0;
        tick();
        tick();
        check("rst_q",    {24'd0, Q},  32'h0000_0000);
        check("rst_qn",   {24'd0, QN}, 32'h0000_00FF);
        check("rst_busy", {31'd0, SHIFT_BUSY}, 32'd0);
        check("rst_done", {31'd0, SHIFT_DONE}, 32'd0);
        RST = 1'b0;

        for (int i = 0; i < 5; i++) begin
            apply(vecs[i].en, vecs[i].se, vecs[i].d, vecs[i].si, vecs[i].exp_q);
        end

        // Mid-cycle reset pulse clears immediately.
        EN = 1'b0; SE = 1'b0;
        #2 RST = 1'b1;
        #1;
        check("async_rst_q",  {24'd0, Q},  32'h0000_0000);
        check("async_rst_qn", {24'd0, QN}, 32'h0000_00FF);
        #1 RST = 1'b0;
        tick();

        for (int i = 5; i < 7; i++) begin
            apply(vecs[i].en, vecs[i].se, vecs[i].d, vecs[i].si, vecs[i].exp_q);
        end

        // Auto-shift, then the same with interference.
        apply(1'b1, 1'b0, 8'hA5, 2'b00, 8'hA5);
        run_auto(1'b0);
        apply(1'b1, 1'b0, 8'hA5, 2'b00, 8'hA5);
        run_auto(1'b1);

        // Reset mid-shift abandons the shift.
        apply(1'b1, 1'b0, 8'hA5, 2'b00, 8'hA5);
        EN = 1'b0; SI = 2'b01; SHIFT_START = 1'b1;
        tick();                                  // t0
        SHIFT_START = 1'b0;
        tick();                                  // t1
        tick();                                  // t2
        check("mid_busy", {31'd0, SHIFT_BUSY}, 32'd1);
        RST = 1'b1;
        #1;
        check("mid_rst_q",    {24'd0, Q}, 32'h0000_0000);
        check("mid_rst_busy", {31'd0, SHIFT_BUSY}, 32'd0);
        check("mid_rst_done", {31'd0, SHIFT_DONE}, 32'd0);
        #1 RST = 1'b0;
        tick();
        check("after_rst_busy", {31'd0, SHIFT_BUSY}, 32'd0);

        SI = 2'b11; SHIFT_START = 1'b1;
        tick();                                  // t0
        SHIFT_START = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (SHIFT_BUSY) busy_cnt++;
            if (SHIFT_DONE) done_cnt++;
            tick();
        end
        check("restart_busy_cycles", busy_cnt, 32'd4);
        check("restart_done_pulses", done_cnt, 32'd1);
        check("restart_q", {24'd0, Q}, 32'h0000_00FF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_scan_reg_bank
